input_sequence_capture: RTL
===========================

Name: input_sequence_capture

Overview:
- Upstream input stage for a round: debounces the eight player buttons, turns each clean press into a button index, and buffers up to 16 indices in press order.
- Signals completion once the level-dependent number of presses is stored.
- Sits between the board buttons and the round comparison logic; it is armed by the end of pattern display and cleared between rounds.

Parameters:
- DEBOUNCE_CYCLES, 20, consecutive identical clk samples needed to accept a button level change (20 ms at 1 kHz).
- MAX_LEN, 16, buffer depth in entries.
- IDX_W, 3, width of one stored button index.

Ports:
- clk  input  1  1 kHz system clock; all logic on posedge.
- rst  input  1  asynchronous reset, active-low.
- enable  input  1  level, high when pattern display has finished; sampled only in IDLE.
- clear  input  1  synchronous one-cycle pulse; starts a new round.
- level  input  3  one-hot level: 001 = 8 presses, 010 = 12, 100 = 16; any other code is invalid.
- btn  input  8  raw buttons, active-high; bit 0 = button 1.
- seq_flat  output  48  entry k (0..15) on bits [3k+2:3k], value = button number − 1.
- valid_mask  output  16  bit k high when entry k is written.
- count  output  5  number of entries stored, 0..16.
- done  output  1  high from target reached until clear or rst.
- multi_err  output  1  one-cycle pulse when a simultaneous press is rejected.
- led_echo  output  8  debounced button levels while in CAPTURE, else 0.

Behaviour:
- Reset (rst low, async):
  - state = IDLE.
  - All debounce counters and debounced levels = 0.
  - seq_flat, valid_mask, count, done, multi_err, led_echo = 0.
  - Reset mid-capture discards all entries.
- Debounce, per button, always running in every state:
  - Counter counts consecutive cycles in which raw btn differs from the debounced level.
  - The counter resets when raw btn matches the debounced level.
  - On reaching DEBOUNCE_CYCLES, the debounced level toggles and the counter returns to 0.
  - A raw level that changes at edge t is first sampled at t+1 and flips the debounced level at edge t+DEBOUNCE_CYCLES.
  - A glitch shorter than DEBOUNCE_CYCLES has no effect.
- Press event: rising edge of a debounced level, detected the cycle after it flips.
- Target: 8, 12 or 16 from level, latched on leaving IDLE. An invalid level keeps the block in IDLE.
- FSM states:
  - IDLE: on enable = 1 with a valid level, go to ARMED.
  - ARMED: wait until all 8 debounced levels are 0, then go to CAPTURE. This stops a button held over from pattern display from counting.
  - CAPTURE, exactly one press event in a cycle:
    - Write its index to entry[count], set valid_mask[count], count += 1.
    - Visible one edge after detection.
    - If the new count equals target, go to DONE and assert done on that same edge.
  - CAPTURE, two or more press events in the same cycle: write nothing, pulse multi_err for 1 cycle.
  - CAPTURE: a press while another button is still held is accepted as a normal event.
  - DONE: done = 1; all events are ignored; count never exceeds the target or 16.
- clear, any state:
  - Next edge: state = IDLE.
  - seq_flat, valid_mask, count, done = 0.
  - Debounce state is kept.
  - clear has priority over a press event in the same cycle.
- enable and level changes after IDLE are ignored until clear.
- Unwritten entries read 0, so the consumer compares against a pattern masked with valid_mask.

Test Plan (DEBOUNCE_CYCLES = 4):
- Reset, level = 001, enable = 1, eight clean presses of buttons 3,1,8,2,2,5,7,4 (each held 6 cycles, released 6) -> entries 2,0,7,1,1,4,6,3; count = 8; valid_mask = 0x00FF; done rises on the edge after the 8th press is detected; a 9th press leaves everything unchanged.
- Button 5 pulses high for 3 cycles, then a 5-cycle press -> exactly one entry (value 4); count = 1.
- Buttons 2 and 6 rise on the same cycle in CAPTURE -> multi_err high for 1 cycle; count stays 0.
- Button 1 held high when enable rises -> stays ARMED, no entry; after release and a fresh press of button 1 -> entry 0 = 0, count = 1.
- level = 100, 10 presses, then clear -> count = 0, valid_mask = 0, done = 0, state IDLE; the next enable with level = 010 needs 12 presses for done.
- rst low asynchronously mid-capture (count = 5) -> all outputs 0 immediately; after rst release the block stays IDLE until enable.

Source files
------------

// File: rtl/input_sequence_capture.sv
// input_sequence_capture
//   Player input stage for one round: debounces the eight raw buttons,
//   converts each clean press into a button index and stores up to MAX_LEN
//   indices in press order. It raises done once the level-dependent number of
//   presses has been captured.
//
// Ports
//   clk        system clock (1 kHz), rising edge
//   rst        asynchronous reset, active-low
//   enable     pattern display finished; only looked at in IDLE
//   clear      one-cycle pulse, returns to IDLE and empties the buffer
//   level      one-hot round level: 001 -> 8, 010 -> 12, 100 -> 16 presses
//   btn        raw buttons, active-high, bit 0 = button 1
//   seq_flat   entry k on bits [IDX_W*k +: IDX_W], value = button number - 1
//   valid_mask bit k set once entry k is written
//   count      number of stored entries
//   done       target reached, held until clear or rst
//   multi_err  one-cycle pulse when simultaneous presses are rejected
//   led_echo   debounced button levels while capturing, else 0
module input_sequence_capture #(
   parameter int unsigned DEBOUNCE_CYCLES = 20,
   parameter int unsigned MAX_LEN         = 16,
   parameter int unsigned IDX_W           = 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         enable,
   input  logic                         clear,
   input  logic [2:0]                   level,
   input  logic [7:0]                   btn,
   output logic [MAX_LEN*IDX_W-1:0]     seq_flat,
   output logic [MAX_LEN-1:0]           valid_mask,
   output logic [$clog2(MAX_LEN+1)-1:0] count,
   output logic                         done,
   output logic                         multi_err,
   output logic [7:0]                   led_echo
);

   localparam int unsigned CNT_W = $clog2(MAX_LEN + 1);
   localparam int unsigned PTR_W = $clog2(MAX_LEN);
   localparam int unsigned DB_W  = $clog2(DEBOUNCE_CYCLES + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ARMED,
      S_CAPTURE,
      S_DONE
   } state_t;

   state_t           state;
   logic [DB_W-1:0]  db_cnt [8];
   logic [7:0]       deb;
   logic [7:0]       deb_q;
   logic [CNT_W-1:0] target;

   logic [7:0]       rise;
   logic [3:0]       n_ev;
   logic [IDX_W-1:0] ev_idx;
   logic [CNT_W-1:0] lvl_target;
   logic [CNT_W-1:0] count_inc;
   logic [PTR_W-1:0] wr_ptr;

   // Press decode: rising edges of the debounced levels, one cycle after the flip.
   always_comb begin
      rise   = deb & ~deb_q;
      n_ev   = '0;
      ev_idx = '0;
      for (int unsigned i = 0; i < 8; i++) begin
         if (rise[i]) begin
            n_ev   = n_ev + 4'd1;
            ev_idx = IDX_W'(i);
         end
      end
   end

   // Invalid level codes decode to 0, which keeps the block in IDLE.
   always_comb begin
      case (level)
         3'b001:  lvl_target = CNT_W'(8);
         3'b010:  lvl_target = CNT_W'(12);
         3'b100:  lvl_target = CNT_W'(16);
         default: lvl_target = '0;
      endcase
   end

   assign count_inc = count + 1'b1;
   assign wr_ptr    = count[PTR_W-1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         for (int unsigned i = 0; i < 8; i++) db_cnt[i] <= '0;
         deb        <= '0;
         deb_q      <= '0;
         target     <= '0;
         seq_flat   <= '0;
         valid_mask <= '0;
         count      <= '0;
         done       <= 1'b0;
         multi_err  <= 1'b0;
         led_echo   <= '0;
      end else begin
         // Debounce runs in every state and is not affected by clear.
         for (int unsigned i = 0; i < 8; i++) begin
            if (btn[i] == deb[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               deb[i]    <= ~deb[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
         deb_q     <= deb;
         multi_err <= 1'b0;
         led_echo  <= (state == S_CAPTURE) ? deb : '0;

         if (clear) begin
            state      <= S_IDLE;
            seq_flat   <= '0;
            valid_mask <= '0;
            count      <= '0;
            done       <= 1'b0;
            led_echo   <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (enable && (lvl_target != '0)) begin
                     target <= lvl_target;
                     state  <= S_ARMED;
                  end
               end
               S_ARMED: begin
                  // A button still held from pattern display must be released first.
                  if (deb == '0) state <= S_CAPTURE;
               end
               S_CAPTURE: begin
                  if (n_ev == 4'd1) begin
                     seq_flat[wr_ptr*IDX_W +: IDX_W] <= ev_idx;
                     valid_mask[wr_ptr]              <= 1'b1;
                     count                           <= count_inc;
                     if (count_inc == target) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                     end
                  end else if (n_ev > 4'd1) begin
                     multi_err <= 1'b1;
                  end
               end
               S_DONE: begin
                  done <= 1'b1;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule
